// File: rtl/result_collector_if.sv
// Handshake/bus bundle between the MAC output serializer, the result
// collector and the host readback logic.
//   master : drives start, in_valid, in_data, rd_addr; observes status/readback
//   slave  : the collector itself (consumes stream, produces status/readback)
interface result_collector_if #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned N      = 8,
  parameter int unsigned ADDR_W = 6
);
  logic                   start;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      rd_data;
  logic                   busy;
  logic                   done;
  logic                   overrun;
  logic [ADDR_W:0]        wr_count;
  logic [DATA_W-1:0]      row_max;
  logic [$clog2(N)-1:0]   row_max_idx;
  logic                   row_max_valid;

  modport master (
    output start, in_valid, in_data, rd_addr,
    input  rd_data, busy, done, overrun, wr_count, row_max, row_max_idx, row_max_valid
  );

  modport slave (
    input  start, in_valid, in_data, rd_addr,
    output rd_data, busy, done, overrun, wr_count, row_max, row_max_idx, row_max_valid
  );
endinterface

// File: rtl/result_collector.sv
// Collects one row-major N x N result matrix from the serialized MAC stream
// into an internal RAM, reports each completed row's maximum and offers a
// registered (1-cycle) read port.
// Ports:
//   clk          system clock, posedge
//   rst          asynchronous active-high reset
//   bus (slave)  start/in_valid/in_data stream in, rd_addr/rd_data readback,
//                busy/done/overrun/wr_count status, row_max* row report
module result_collector #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned N      = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  result_collector_if.slave  bus
);

  localparam int unsigned ROW_W = $clog2(N);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = N * N;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ROW_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [CNT_W-1:0]    r_wr_count;
  logic [DATA_W-1:0]   r_run_max;
  logic                r_busy;
  logic                r_done;
  logic                r_overrun;
  logic [DATA_W-1:0]   r_row_max;
  logic [ROW_W-1:0]    r_row_max_idx;
  logic                r_row_max_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_row_end;
  logic                w_last;
  logic [DATA_W-1:0]   w_cur_max;

  // A start on the same cycle as a valid element wins; the element is discarded.
  assign w_accept  = (r_state == S_COLLECT) && bus.in_valid && !bus.start;
  assign w_row_end = (r_col == ROW_W'(N - 1));
  assign w_last    = (r_wr_addr == ADDR_W'(DEPTH - 1));
  // Running max restarts from the first element of each row.
  assign w_cur_max = ((r_col != '0) && (r_run_max > bus.in_data)) ? r_run_max : bus.in_data;

  // Control FSM, counters and row-max reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_wr_addr       <= '0;
      r_col           <= '0;
      r_row           <= '0;
      r_wr_count      <= '0;
      r_run_max       <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_overrun       <= 1'b0;
      r_row_max       <= '0;
      r_row_max_idx   <= '0;
      r_row_max_valid <= 1'b0;
    end else begin
      r_row_max_valid <= 1'b0;
      if (bus.start) begin
        r_state    <= S_COLLECT;
        r_wr_addr  <= '0;
        r_col      <= '0;
        r_row      <= '0;
        r_wr_count <= '0;
        r_run_max  <= '0;
        r_overrun  <= 1'b0;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
      end else begin
        case (r_state)
          S_COLLECT: begin
            if (w_accept) begin
              r_wr_addr  <= r_wr_addr + ADDR_W'(1);
              r_wr_count <= r_wr_count + CNT_W'(1);
              r_run_max  <= w_cur_max;
              if (w_row_end) begin
                r_col           <= '0;
                r_row           <= r_row + ROW_W'(1);
                r_row_max       <= w_cur_max;
                r_row_max_idx   <= r_row;
                r_row_max_valid <= 1'b1;
              end else begin
                r_col <= r_col + ROW_W'(1);
              end
              if (w_last) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_IDLE, S_DONE: begin
            if (bus.in_valid) r_overrun <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Result RAM; not reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_addr] <= bus.in_data;
  end

  // Registered read port, read-before-write on address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_mem[bus.rd_addr];
  end

  assign bus.rd_data       = r_rd_data;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.overrun       = r_overrun;
  assign bus.wr_count      = r_wr_count;
  assign bus.row_max       = r_row_max;
  assign bus.row_max_idx   = r_row_max_idx;
  assign bus.row_max_valid = r_row_max_valid;

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: the driver pushes expected row maxima
// and readback values into queues; a monitor pops and compares them whenever
// the DUT presents row_max_valid or a read result is due.
module tb_result_collector;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned N      = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = N * N;

  logic clk;
  logic rst;

  result_collector_if #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) bus ();

  result_collector #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] stim      [DEPTH];
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [21:0]       exp_rm [$];   // {row_idx, row_max}
  logic [DATA_W-1:0] exp_rd [$];
  bit                rd_req   = 1'b0;
  bit                rd_req_d = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT row reports and read results against the queues.
  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (bus.row_max_valid) begin
      if (exp_rm.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL row_max_unexpected: got idx %0d max %0h expected no pulse",
                 bus.row_max_idx, bus.row_max);
      end else begin
        logic [21:0] e;
        e = exp_rm.pop_front();
        check("row_max_idx", 32'(bus.row_max_idx), 32'(e[21:19]));
        check("row_max", 32'(bus.row_max), 32'(e[18:0]));
      end
    end
    if (rd_req_d) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data_unexpected: got %0h expected no read", bus.rd_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_rd.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(e));
      end
    end
  end

  // Expected maxima of every row fully contained in the first count elements.
  task automatic push_row_max(input int count);
    for (int r = 0; r < count / int'(N); r++) begin
      logic [DATA_W-1:0] m;
      logic [2:0]        ri;
      m = '0;
      for (int c = 0; c < int'(N); c++)
        if (stim[r*int'(N)+c] > m) m = stim[r*int'(N)+c];
      ri = 3'(r);
      exp_rm.push_back({ri, m});
    end
  endtask

  task automatic collect(input int count, input int gap, input bit rbw);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("wr_count_cleared", 32'(bus.wr_count), 32'd0);
    check("overrun_cleared", 32'(bus.overrun), 32'd0);
    check("done_after_start", 32'(bus.done), 32'd0);
    push_row_max(count);
    for (int i = 0; i < count; i++) begin
      if (i == count - 1 && count == int'(DEPTH)) begin
        check("busy_before_last", 32'(bus.busy), 32'd1);
        check("done_before_last", 32'(bus.done), 32'd0);
      end
      if (rbw && i == 0) begin
        bus.rd_addr = '0;
        rd_req = 1'b1;
        exp_rd.push_back(model_mem[0]);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      model_mem[i] = stim[i];
      tick();
      bus.in_valid = 1'b0;
      rd_req = 1'b0;
      repeat (gap) tick();
    end
    if (count == int'(DEPTH)) begin
      check("done_after_last", 32'(bus.done), 32'd1);
      check("busy_after_last", 32'(bus.busy), 32'd0);
      check("wr_count_full", 32'(bus.wr_count), 32'd64);
    end else begin
      check("wr_count_partial", 32'(bus.wr_count), 32'(count));
      check("busy_partial", 32'(bus.busy), 32'd1);
    end
  endtask

  task automatic readback();
    for (int k = 0; k < int'(DEPTH); k++) begin
      bus.rd_addr = ADDR_W'(k);
      exp_rd.push_back(model_mem[k]);
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    check({tag, "_wr_count"}, 32'(bus.wr_count), 32'd0);
    check({tag, "_row_max"}, 32'(bus.row_max), 32'd0);
    check({tag, "_row_max_idx"}, 32'(bus.row_max_idx), 32'd0);
    check({tag, "_row_max_valid"}, 32'(bus.row_max_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_addr  = '0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Element while IDLE is dropped and flagged.
    bus.in_valid = 1'b1;
    bus.in_data  = 19'h00055;
    tick();
    bus.in_valid = 1'b0;
    check("idle_overrun", 32'(bus.overrun), 32'd1);
    check("idle_wr_count", 32'(bus.wr_count), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Scenario 1: value = address, back-to-back.
    for (int i = 0; i < int'(DEPTH); i++) stim[i] = DATA_W'(i);
    collect(64, 0, 1'b0);
    readback();

    // Scenario 2: {r, 5r+7, 0...}, row 3 holds the all-ones peak.
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        stim[r*int'(N)+c] = (c == 0) ? DATA_W'(r) : (c == 1) ? DATA_W'(5*r+7) : '0;
    stim[3*int'(N)+2] = 19'h7FFFF;
    collect(64, 0, 1'b1);
    readback();

    // Scenario 3: same data, in_valid pattern 1,0,0.
    collect(64, 2, 1'b0);
    readback();

    // Scenario 4: element while DONE is dropped and flagged.
    bus.in_valid = 1'b1;
    bus.in_data  = 19'h12345;
    tick();
    bus.in_valid = 1'b0;
    check("done_overrun", 32'(bus.overrun), 32'd1);
    check("done_wr_count", 32'(bus.wr_count), 32'd64);
    check("done_hold", 32'(bus.done), 32'd1);
    readback();

    // Scenario 5: restart after 20 elements, then a full new matrix.
    for (int i = 0; i < int'(DEPTH); i++) stim[i] = DATA_W'(32'h100 + 32'(i));
    collect(20, 0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) stim[i] = DATA_W'(32'h40000 - 32'(7*i));
    collect(64, 0, 1'b1);
    readback();

    // Scenario 6: reset in the middle of row 1.
    for (int i = 0; i < int'(DEPTH); i++) stim[i] = DATA_W'(32'h300 + 32'(i));
    collect(12, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrow_reset");
    tick();
    rst = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 19'h00077;
    tick();
    bus.in_valid = 1'b0;
    check("post_reset_overrun", 32'(bus.overrun), 32'd1);
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) stim[i] = DATA_W'(i);
    collect(64, 0, 1'b0);
    readback();

    repeat (3) tick();
    check("row_max_queue_empty", 32'(exp_rm.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
